// File: rtl/ex_muldiv_unit_if.sv
// EX-stage M-extension handshake bundle.
// master drives the op and operands, slave returns busy/done/result.
interface ex_muldiv_unit_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic [2:0]      funct3;
  logic [XLEN-1:0] rs1_val_EX;
  logic [XLEN-1:0] rs2_val_EX;
  logic [XLEN-1:0] alu_result_MEM;
  logic [XLEN-1:0] write_data_core;
  logic [1:0]      forwardA;
  logic [1:0]      forwardB;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;

  modport master (
    output start, funct3,
    output rs1_val_EX, rs2_val_EX,
    output alu_result_MEM, write_data_core,
    output forwardA, forwardB, flush,
    input  busy, done, result
  );

  modport slave (
    input  start, funct3,
    input  rs1_val_EX, rs2_val_EX,
    input  alu_result_MEM, write_data_core,
    input  forwardA, forwardB, flush,
    output busy, done, result
  );
endinterface

// File: rtl/ex_muldiv_unit.sv
// RV32M execute unit: registered multiply, iterative restoring divide.
// Define MULDIV_FAST_MUL_EN to finish multiplies in the accept cycle.
module ex_muldiv_unit #(
  parameter int XLEN      = 32,
  parameter int DIV_ITERS = 32
) (
  input logic             clk,
  input logic             rst_n,
  ex_muldiv_unit_if.slave bus
);

  localparam int CW = $clog2(DIV_ITERS);
  localparam logic [CW-1:0] CNT_LOAD =
    CW'(DIV_ITERS - 1);
  localparam logic [XLEN-1:0] MIN_NEG =
    {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

`ifdef MULDIV_FAST_MUL_EN
  localparam state_t MUL_DST = S_DONE;
`else
  localparam state_t MUL_DST = S_MUL;
`endif

  state_t r_state;
  state_t w_next;

  logic [XLEN-1:0] r_result;
  logic [XLEN-1:0] r_quo;
  logic [XLEN-1:0] r_rem;
  logic [XLEN-1:0] r_dvs;
  logic [CW-1:0]   r_cnt;
  logic            r_is_rem;
  logic            r_qneg;
  logic            r_rneg;
  logic            r_special;
`ifndef MULDIV_FAST_MUL_EN
  logic [XLEN-1:0] r_a;
  logic [XLEN-1:0] r_b;
  logic [1:0]      r_mop;
`endif

  logic [XLEN-1:0] w_opa;
  logic [XLEN-1:0] w_opb;
  logic            w_open;
  logic            w_accept;
  logic            w_is_mul;
  logic            w_is_rem;
  logic            w_sgn;
  logic            w_dz;
  logic            w_ovf;
  logic            w_special;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_a_mag;
  logic [XLEN-1:0] w_b_mag;

  always_comb begin
    unique case (bus.forwardA)
      2'b10:   w_opa = bus.alu_result_MEM;
      2'b01:   w_opa = bus.write_data_core;
      default: w_opa = bus.rs1_val_EX;
    endcase
  end

  always_comb begin
    unique case (bus.forwardB)
      2'b10:   w_opb = bus.alu_result_MEM;
      2'b01:   w_opb = bus.write_data_core;
      default: w_opb = bus.rs2_val_EX;
    endcase
  end

  assign w_open   = (r_state == S_IDLE) ||
                    (r_state == S_DONE);
  assign w_accept = bus.start & ~bus.flush & w_open;

  assign w_is_mul = ~bus.funct3[2];
  assign w_is_rem = bus.funct3[1];
  assign w_sgn    = ~bus.funct3[0];

  assign w_dz  = (w_opb == '0);
  assign w_ovf = w_sgn & (w_opa == MIN_NEG) &
                 (w_opb == '1);
  assign w_special = w_dz | w_ovf;

  assign w_a_neg = w_sgn & w_opa[XLEN-1];
  assign w_b_neg = w_sgn & w_opb[XLEN-1];
  assign w_a_mag = w_a_neg ? -w_opa : w_opa;
  assign w_b_mag = w_b_neg ? -w_opb : w_opb;

  // Multiplier sources: live operands in the fast build, captured otherwise
  logic [XLEN-1:0]   w_mx;
  logic [XLEN-1:0]   w_my;
  logic [1:0]        w_mop;
  logic              w_mx_sx;
  logic              w_my_sx;
  logic [2*XLEN-1:0] w_mx_ext;
  logic [2*XLEN-1:0] w_my_ext;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_mul_res;

`ifdef MULDIV_FAST_MUL_EN
  assign w_mx  = w_opa;
  assign w_my  = w_opb;
  assign w_mop = bus.funct3[1:0];
`else
  assign w_mx  = r_a;
  assign w_my  = r_b;
  assign w_mop = r_mop;
`endif

  assign w_mx_sx  = (w_mop != 2'b11) & w_mx[XLEN-1];
  assign w_my_sx  = ~w_mop[1] & w_my[XLEN-1];
  assign w_mx_ext = {{XLEN{w_mx_sx}}, w_mx};
  assign w_my_ext = {{XLEN{w_my_sx}}, w_my};
  assign w_prod   = w_mx_ext * w_my_ext;
  assign w_mul_res = (w_mop == 2'b00) ?
                     w_prod[XLEN-1:0] :
                     w_prod[2*XLEN-1:XLEN];

  logic [XLEN:0]   w_sh;
  logic [XLEN:0]   w_sub;
  logic            w_fits;
  logic [XLEN-1:0] w_fix;

  assign w_sh   = {r_rem, r_quo[XLEN-1]};
  assign w_sub  = w_sh - {1'b0, r_dvs};
  assign w_fits = ~w_sub[XLEN];

  assign w_fix = r_is_rem ?
                 (r_rneg ? -r_rem : r_rem) :
                 (r_qneg ? -r_quo : r_quo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (w_accept) begin
          if (w_is_mul)       w_next = MUL_DST;
          else if (w_special) w_next = S_FIX;
          else                w_next = S_DIV;
        end else if (r_state == S_DONE) begin
          w_next = S_IDLE;
        end
      end
      S_MUL: w_next = S_DONE;
      S_DIV: if (r_cnt == '0) w_next = S_FIX;
      S_FIX: w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
    if (bus.flush) w_next = S_IDLE;
  end

  always_comb begin
    bus.busy = 1'b0;
    bus.done = 1'b0;
    unique case (r_state)
      S_MUL, S_DIV, S_FIX: bus.busy = 1'b1;
      S_DONE:              bus.done = 1'b1;
      default: ;
    endcase
    if (w_accept) bus.busy = 1'b1;
  end

  assign bus.result = r_result;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_quo     <= '0;
      r_rem     <= '0;
      r_dvs     <= '0;
      r_cnt     <= '0;
      r_is_rem  <= 1'b0;
      r_qneg    <= 1'b0;
      r_rneg    <= 1'b0;
      r_special <= 1'b0;
`ifndef MULDIV_FAST_MUL_EN
      r_a       <= '0;
      r_b       <= '0;
      r_mop     <= '0;
`endif
    end else if (w_accept) begin
      r_is_rem  <= w_is_rem;
      r_qneg    <= w_a_neg ^ w_b_neg;
      r_rneg    <= w_a_neg;
      r_quo     <= w_a_mag;
      r_dvs     <= w_b_mag;
      r_rem     <= '0;
      r_cnt     <= CNT_LOAD;
      r_special <= w_special;
`ifdef MULDIV_FAST_MUL_EN
      if (w_is_mul) r_result <= w_mul_res;
`else
      r_a       <= w_opa;
      r_b       <= w_opb;
      r_mop     <= bus.funct3[1:0];
`endif
      if (!w_is_mul && w_special) begin
        unique case (1'b1)
          w_dz:
            r_result <= w_is_rem ? w_opa : '1;
          w_ovf:
            r_result <= w_is_rem ? '0 : MIN_NEG;
        endcase
      end
    end else if (!bus.flush) begin
      unique case (r_state)
`ifndef MULDIV_FAST_MUL_EN
        S_MUL: r_result <= w_mul_res;
`endif
        S_DIV: begin
          r_rem <= w_fits ? w_sub[XLEN-1:0] :
                            w_sh[XLEN-1:0];
          r_quo <= {r_quo[XLEN-2:0], w_fits};
          r_cnt <= r_cnt - CW'(1);
        end
        S_FIX: if (!r_special) r_result <= w_fix;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: vector table, random ops vs model,
// flush / back-to-back / reset sequences.
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ex_muldiv_unit_if u_if ();

  ex_muldiv_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = 2;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] alu;
    logic [31:0] wd;
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[16];

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(
    input logic [2:0] f3,
    input logic [31:0] rs1, input logic [31:0] rs2,
    input logic [31:0] alu, input logic [31:0] wd,
    input logic [1:0] fa, input logic [1:0] fb,
    input logic [31:0] exp, input int lat);
    vec_t v;
    v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2;
    v.alu = alu; v.wd = wd; v.fa = fa; v.fb = fb;
    v.exp = exp; v.lat = lat;
    return v;
  endfunction

  function automatic logic [31:0] sel(
    input logic [1:0] fw, input logic [31:0] rv,
    input logic [31:0] alu, input logic [31:0] wd);
    if (fw == 2'b10) return alu;
    if (fw == 2'b01) return wd;
    return rv;
  endfunction

  // Plain-arithmetic RV32M reference
  function automatic logic [31:0] ref_op(
    input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint ua = longint'({32'h0, a});
    longint ub = longint'({32'h0, b});
    int ia = $signed(a);
    int ib = $signed(b);
    logic [63:0] p;
    logic ovf;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return 32'h8000_0000;
        return 32'(ia / ib);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        return 32'(ia % ib);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(
    input logic [2:0] f3,
    input logic [31:0] a, input logic [31:0] b);
    if (!f3[2]) return MUL_LAT;
    if (b == 0) return 2;
    if (!f3[0] && a == 32'h8000_0000 &&
        b == 32'hFFFF_FFFF) return 2;
    return 34;
  endfunction

  task automatic set_in(input vec_t v);
    u_if.funct3          = v.f3;
    u_if.rs1_val_EX      = v.rs1;
    u_if.rs2_val_EX      = v.rs2;
    u_if.alu_result_MEM  = v.alu;
    u_if.write_data_core = v.wd;
    u_if.forwardA        = v.fa;
    u_if.forwardB        = v.fb;
    u_if.start           = 1'b1;
  endtask

  // Called #1 after the accept-cycle negedge
  task automatic wait_done(output int lat,
                           output logic [31:0] res,
                           output bit bok);
    lat = -1;
    res = 'x;
    bok = (u_if.busy === 1'b1);
    for (int i = 1; i <= 60; i++) begin
      @(negedge clk);
      u_if.start = 1'b0;
      u_if.flush = 1'b0;
      #1;
      if (u_if.done === 1'b1) begin
        lat = i;
        res = u_if.result;
        if (u_if.busy !== 1'b0) bok = 1'b0;
        break;
      end
      if (u_if.busy !== 1'b1) bok = 1'b0;
    end
  endtask

  task automatic run_vec(input string nm, input vec_t v);
    int lat;
    logic [31:0] res;
    bit bok;
    @(negedge clk);
    set_in(v);
    #1;
    wait_done(lat, res, bok);
    chk({nm, " result"}, res, v.exp);
    chk({nm, " latency"}, 32'(lat), 32'(v.lat));
    chk({nm, " busy"}, {31'b0, bok}, 32'd1);
  endtask

  vec_t v;
  vec_t mulv;
  int lat;
  logic [31:0] res;
  logic [31:0] a;
  logic [31:0] b;
  bit bok;
  bit seen;

  initial begin
    u_if.start = 1'b0;
    u_if.flush = 1'b0;
    u_if.funct3 = 3'd0;
    u_if.rs1_val_EX = '0;
    u_if.rs2_val_EX = '0;
    u_if.alu_result_MEM = '0;
    u_if.write_data_core = '0;
    u_if.forwardA = 2'b00;
    u_if.forwardB = 2'b00;

    #12;
    chk("reset busy", {31'b0, u_if.busy}, 32'd0);
    chk("reset done", {31'b0, u_if.done}, 32'd0);
    chk("reset result", u_if.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    vt[0]  = mk(3'd0, 7, 32'hFFFF_FFFD, 32'hDEAD_BEEF, 1,
                2'b00, 2'b00, 32'hFFFF_FFEB, MUL_LAT);
    vt[1]  = mk(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0,
                2'b00, 2'b00, 32'hFFFF_FFFE, MUL_LAT);
    vt[2]  = mk(3'd2, 32'hFFFF_FFFF, 2, 0, 0,
                2'b00, 2'b00, 32'hFFFF_FFFF, MUL_LAT);
    vt[3]  = mk(3'd1, 32'h8000_0000, 32'h8000_0000, 0, 0,
                2'b00, 2'b00, 32'h4000_0000, MUL_LAT);
    vt[4]  = mk(3'd4, 32'hFFFF_FFF9, 2, 0, 0,
                2'b00, 2'b00, 32'hFFFF_FFFD, 34);
    vt[5]  = mk(3'd6, 32'hFFFF_FFF9, 2, 0, 0,
                2'b00, 2'b00, 32'hFFFF_FFFF, 34);
    vt[6]  = mk(3'd5, 100, 7, 0, 0,
                2'b00, 2'b00, 14, 34);
    vt[7]  = mk(3'd7, 100, 7, 0, 0,
                2'b00, 2'b00, 2, 34);
    vt[8]  = mk(3'd5, 5, 0, 9, 9,
                2'b00, 2'b00, 32'hFFFF_FFFF, 2);
    vt[9]  = mk(3'd6, 5, 0, 9, 9,
                2'b00, 2'b00, 5, 2);
    vt[10] = mk(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
                2'b00, 2'b00, 32'h8000_0000, 2);
    vt[11] = mk(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0,
                2'b00, 2'b00, 0, 2);
    vt[12] = mk(3'd5, 1000, 1000, 12, 4,
                2'b10, 2'b01, 3, 34);
    vt[13] = mk(3'd5, 20, 5, 99, 77,
                2'b11, 2'b00, 4, 34);
    vt[14] = mk(3'd0, 6, 0, 9, 1,
                2'b00, 2'b10, 54, MUL_LAT);
    vt[15] = mk(3'd7, 32'h3039, 0, 1, 1,
                2'b00, 2'b00, 32'h3039, 2);

    for (int i = 0; i < 16; i++)
      run_vec($sformatf("vec%0d", i), vt[i]);

    for (int i = 0; i < 40; i++) begin
      v.f3  = 3'($urandom_range(0, 7));
      v.rs1 = $urandom;
      v.rs2 = $urandom;
      v.alu = $urandom;
      v.wd  = $urandom;
      v.fa  = 2'($urandom_range(0, 3));
      v.fb  = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 7))
        0: begin v.rs2 = 0; v.fb = 2'b00; end
        1: begin
          v.rs1 = 32'h8000_0000; v.fa = 2'b00;
          v.rs2 = 32'hFFFF_FFFF; v.fb = 2'b00;
        end
        2: v.rs2 = v.rs2 >> $urandom_range(1, 28);
        default: ;
      endcase
      a = sel(v.fa, v.rs1, v.alu, v.wd);
      b = sel(v.fb, v.rs2, v.alu, v.wd);
      v.exp = ref_op(v.f3, a, b);
      v.lat = ref_lat(v.f3, a, b);
      run_vec($sformatf("rnd%0d f3=%0d", i, v.f3), v);
    end

    // Flush in the DONE cycle keeps that cycle's done
    v = mk(3'd7, 100, 7, 0, 0, 2'b00, 2'b00, 2, 34);
    @(negedge clk);
    set_in(v);
    #1;
    wait_done(lat, res, bok);
    chk("fdone latency", 32'(lat), 34);
    u_if.flush = 1'b1;
    #1;
    chk("fdone done", {31'b0, u_if.done}, 32'd1);
    chk("fdone result", u_if.result, 32'd2);
    @(negedge clk);
    u_if.flush = 1'b0;
    #1;
    chk("fdone next done", {31'b0, u_if.done}, 32'd0);
    chk("fdone next result", u_if.result, 32'd2);

    // Flush at N+10 of a DIV, new MUL at N+12
    v = mk(3'd4, 32'hFFFF_FFF9, 2, 0, 0,
           2'b00, 2'b00, 0, 0);
    @(negedge clk);
    set_in(v);
    #1;
    chk("flush accept busy", {31'b0, u_if.busy}, 32'd1);
    seen = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      u_if.start = 1'b0;
      if (i == 10) u_if.flush = 1'b1;
      #1;
      if (u_if.done !== 1'b0) seen = 1'b1;
      if (u_if.busy !== 1'b1) seen = 1'b1;
    end
    chk("flush pre", {31'b0, seen}, 32'd0);
    @(negedge clk);
    u_if.flush = 1'b0;
    #1;
    chk("flush busy", {31'b0, u_if.busy}, 32'd0);
    chk("flush done", {31'b0, u_if.done}, 32'd0);
    chk("flush result", u_if.result, 32'd2);
    mulv = vt[0];
    run_vec("after flush", mulv);

    // Start in the DONE cycle is taken back-to-back
    v = mk(3'd5, 100, 7, 0, 0, 2'b00, 2'b00, 14, 34);
    @(negedge clk);
    set_in(v);
    #1;
    wait_done(lat, res, bok);
    chk("b2b first result", res, 32'd14);
    chk("b2b first latency", 32'(lat), 34);
    set_in(mulv);
    #1;
    chk("b2b done held", {31'b0, u_if.done}, 32'd1);
    wait_done(lat, res, bok);
    chk("b2b second result", res, 32'hFFFF_FFEB);
    chk("b2b second latency", 32'(lat), 32'(MUL_LAT));
    chk("b2b busy", {31'b0, bok}, 32'd1);

    // Reset mid-divide
    v = mk(3'd5, 1000, 3, 0, 0, 2'b00, 2'b00, 0, 0);
    @(negedge clk);
    set_in(v);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      u_if.start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    chk("rst busy", {31'b0, u_if.busy}, 32'd0);
    chk("rst done", {31'b0, u_if.done}, 32'd0);
    chk("rst result", u_if.result, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec("after rst", vt[7]);

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/ex_muldiv_unit.md
Name: ex_muldiv_unit

Overview:
- EX-stage M-extension execute unit for the RV32IM pipeline.
- Consumes the forwarding selects produced for the EX stage (forwardA/forwardB) and builds its operands from the register-read values or the bypass sources.
- Executes MUL/MULH/MULHSU/MULHU with a short fixed latency and DIV/DIVU/REM/REMU with an iterative restoring divider.
- Drives a stall request (`busy`) to hazard control while a result is pending.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- DIV_ITERS, 32, divider iteration count. Must equal XLEN.

Ports:
- clk  in  1  pipeline clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  valid M-type instruction present in EX this cycle.
- funct3  in  3  RV32M op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- rs1_val_EX  in  32  register-file value for rs1.
- rs2_val_EX  in  32  register-file value for rs2.
- alu_result_MEM  in  32  EX/MEM bypass value.
- write_data_core  in  32  MEM/WB bypass value.
- forwardA  in  2  operand-A select: 00 reg, 10 EX/MEM, 01 MEM/WB, 11 treated as 00.
- forwardB  in  2  operand-B select, same encoding as forwardA.
- flush  in  1  synchronous kill of any in-flight op.
- busy  out  1  stall request to hazard control.
- done  out  1  single-cycle result-valid strobe.
- result  out  32  M-op result; held until the next accept.

Behaviour:
- Clocking and reset: one clock, `clk`. Reset is asynchronous and active-low on `rst_n`.
- Reset values: state=IDLE, done=0, result=0, counter=0, internal operand registers=0.
- Operand muxes are combinational from forwardA/forwardB as encoded above.
- Operands and funct3 are captured only on accept.
- accept = start & ~flush & (state==IDLE | state==DONE). A start arriving in the DONE cycle is accepted back-to-back.
- busy = (state in {MUL, DIV, FIX}) | (start & (state==IDLE | state==DONE) & ~flush).
  - busy is combinational in the accept cycle, so EX is held from that cycle onward.
- States: IDLE, MUL, DIV, FIX, DONE.
- Transitions on accept:
  - Multiply ops → MUL.
  - Divide-by-zero or signed overflow (DIV/REM with 0x80000000 / 0xFFFFFFFF) → FIX, with the special result preloaded.
  - Otherwise → DIV, with counter=DIV_ITERS-1.
- MUL → DONE. The 64-bit product is computed with correct signed/unsigned extension per funct3.
  - MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
- DIV iterates one quotient bit per cycle on magnitudes. Counter decrements; at 0 → FIX.
- FIX applies sign correction:
  - Quotient is negated if the operand signs differ (signed ops only).
  - Remainder takes the dividend's sign.
  - Then → DONE.
- DONE: done=1 for exactly one cycle and result is valid. Next state is the accepted op if accept, else IDLE.
- Latency, accept in cycle N:
  - MUL: done in N+2.
  - Special case: done in N+2.
  - DIV/REM: done in N+34.
- Special results:
  - x/0: DIV/DIVU = 0xFFFFFFFF; REM/REMU = dividend.
  - Overflow: DIV = 0x80000000; REM = 0.
- flush has priority over everything:
  - Next state is IDLE; done=0 next cycle; result is unchanged.
  - A flush in the DONE cycle still leaves that cycle's done visible.
- rst_n asserted mid-operation returns all state to the reset values immediately.
- start while busy in MUL, DIV or FIX is ignored. The pipeline is already stalled, so this is legal.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined: multiply ops go accept → DONE directly, so done is in N+1. MUL state is unused. busy is high only in the accept cycle.
- Undefined: multiply uses the registered MUL state, with done in N+2.
- Divide timing is identical in both builds.

Test Plan:
- MUL, A=7, B=0xFFFFFFFD (-3), forward 00/00, accept at N → busy=1 in N and N+1; done=1 and result=0xFFFFFFEB in N+2 (N+1 with MULDIV_FAST_MUL_EN).
- MULHU with 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU with 0xFFFFFFFF (-1)×2 → 0xFFFFFFFF. MULH with 0x80000000×0x80000000 → 0x40000000.
- DIV -7/2 → 0xFFFFFFFD and REM -7/2 → 0xFFFFFFFF, each with done at N+34 and busy high N..N+33. DIVU 100/7 → 14; REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM of the same → 0. All done at N+2.
- forwardA=10 with alu_result_MEM=12, forwardB=01 with write_data_core=4, DIVU → 3. forwardA=11 selects rs1_val_EX.
- Flush at N+10 of a DIV → no done; busy=0 from N+11. A new MUL start at N+12 is accepted and gives the correct result. A start in the DONE cycle is accepted back-to-back.
